zl_rs_encoder: RTL and testbench
================================

# zl_rs_encoder

Systematic Reed-Solomon encoder for the DVB-S outer code, RS(204,188), t=8, over GF(2^8). It sits directly upstream of the inner convolutional stage and is the main consumer of `zl_gf_mul`: one constant-coefficient multiplier per generator tap feeds a parity LFSR. Each packet of `K` message symbols passes through unchanged and is followed by `N-K` parity symbols on a valid/ack stream.

## Interface

Parameters:

- `N`, default 204: codeword length in symbols.
- `K`, default 188: message length in symbols. `N-K` must be even and ≥2.
- `Gf_width`, default 8: symbol width.
- `Gf_poly`, default 285 (0x11D): field polynomial. Only the low `Gf_width` bits are used, matching `zl_gf_mul`.

Ports:

- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data_in_req` input 1: input symbol valid.
- `data_in_ack` output 1: input symbol accepted this cycle when both `req` and `ack` are high.
- `data_in` input `Gf_width`: message symbol.
- `data_out_req` output 1: output symbol valid.
- `data_out_ack` input 1: downstream accepts the output symbol.
- `data_out` output `Gf_width`: codeword symbol.
- `data_out_sop` output 1: high with the first symbol of each codeword.
- `data_out_par` output 1: high while a parity symbol is presented.

## Operation

- Let P = `N-K`. The generator is g(x) = Π(x − α^i) for i = 0..P−1, with α = 0x02. Coefficients g[0..P−1] are elaboration-time constants computed by a constant function (monic term implicit). They are not ports.
- State machine:
  - **DATA**: the symbol counter `cnt` runs 0..K−1.
  - **PARITY**: `cnt` runs 0..P−1.
- **DATA state:**
  - `data_out = data_in`, `data_out_req = data_in_req`, `data_in_ack = data_out_ack` (combinational pass-through, zero latency).
  - On each transfer, fb = `data_in` ^ r[P−1], r[0] ← fb·g[0], and r[i] ← r[i−1] ^ fb·g[i] for i = 1..P−1.
  - `cnt` increments. When the transfer with `cnt` = K−1 completes, go to PARITY with `cnt` = 0.
- **PARITY state:**
  - `data_in_ack` = 0, `data_out_req` = 1, `data_out` = r[P−1], `data_out_par` = 1.
  - On each transfer, r shifts up (r[i] ← r[i−1], r[0] ← 0) and `cnt` increments.
  - When the transfer with `cnt` = P−1 completes, go to DATA with `cnt` = 0. At that point r is all-zero by construction, and the next codeword starts from it.
- `data_out_sop` = 1 when in DATA state, `cnt` = 0, and `data_in_req` = 1.
- There is no stall other than handshake. A transfer is `req & ack`. The LFSR and counter advance only on a transfer.
- Parity symbols are emitted highest-degree first (r[P−1] first).

## Timing

- Reset (async assert, sync deassert via the usual synchronizer upstream):
  - State DATA, `cnt` = 0, all r = 0.
  - Outputs: `data_out_req` = `data_in_req`, and `data_in_ack` = `data_out_ack` (combinational). Registered-state-derived outputs `data_out_par` = 0 and `data_out_sop` follow DATA/`cnt` = 0.
- Reset asserted mid-packet aborts the codeword. The next accepted symbol is message symbol 0 of a fresh codeword with zero LFSR.
- Throughput is one symbol per clock with `data_out_ack` held high. A codeword takes exactly N transfer cycles, and back-to-back codewords have no gap.
- Data symbols have zero latency. The first parity symbol is valid in the cycle after the K-th data transfer.
- In PARITY, `data_out` and `data_out_par` stay stable while `data_out_ack` = 0.
- The DATA→PARITY→DATA wrap is driven only by `cnt` reaching K−1 / P−1 on a transfer. No other input changes the sequence.
- The multiplier path (P × `zl_gf_mul` plus XOR) is single-cycle combinational from `data_in` to r.

## Test plan

- **All-zero message.** Stream 188 × 0x00 with `data_out_ack` = 1 → 204 outputs, all 0x00. `sop` on output 0, `par` on outputs 188..203, `data_in_ack` = 0 during those 16 cycles.
- **Impulse.** Stream 187 × 0x00 then 0x01 → parity outputs equal g[15], g[14], …, g[0] in that order, checked against the bench's software GF model with poly 0x11D.
- **Random packets vs. model.** Stream 50 random packets back-to-back → every codeword matches the bench's RS(204,188) model, and every codeword has all 16 syndromes S_i = c(α^i) equal to zero, i = 0..15.
- **Backpressure.** Randomly drop `data_out_ack` (≈30%) and `data_in_req` (≈30%) → the output sequence is identical to the no-stall run, and `data_out` is stable on every PARITY cycle with ack low.
- **Reset mid-operation.** Assert `rst_n` = 0 for 1 cycle after 100 data symbols, then again after 5 parity symbols → each following packet encodes correctly from a zero state, and `sop` marks its first symbol.
- **Linearity.** Encode A, B, and A^B → parity(A^B) = parity(A) ^ parity(B) for 20 random pairs.

Source files
------------

// File: rtl/zl_rs_encoder.sv
// Systematic RS(N,K) encoder over GF(2^Gf_width): message symbols pass through with zero latency,
// followed by N-K parity symbols from a generator-polynomial LFSR, highest degree first.
module zl_rs_encoder #(
    parameter int unsigned N        = 204,
    parameter int unsigned K        = 188,
    parameter int unsigned Gf_width = 8,
    parameter int unsigned Gf_poly  = 285
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_in_req,
    output logic                data_in_ack,
    input  logic [Gf_width-1:0] data_in,
    output logic                data_out_req,
    input  logic                data_out_ack,
    output logic [Gf_width-1:0] data_out,
    output logic                data_out_sop,
    output logic                data_out_par
);

    localparam int unsigned P      = N - K;
    localparam int unsigned CntMax = (K > P) ? K : P;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [Gf_width-1:0] PolyLow = Gf_poly[Gf_width-1:0];
    localparam logic [Gf_width-1:0] Alpha   = Gf_width'(2);

    typedef logic [P-1:0][Gf_width-1:0] coef_t;

    // Shift-and-add multiply; with one operand constant this folds to an XOR network.
    function automatic logic [Gf_width-1:0] gf_mul(input logic [Gf_width-1:0] a,
                                                   input logic [Gf_width-1:0] b);
        logic [Gf_width-1:0] acc;
        logic [Gf_width-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(Gf_width); i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[Gf_width-2:0], 1'b0} ^ (sh[Gf_width-1] ? PolyLow : '0);
        end
        return acc;
    endfunction

    // g(x) = prod_{i=0}^{P-1} (x - alpha^i); the monic x^P term is implicit.
    function automatic coef_t gen_poly();
        logic [P:0][Gf_width-1:0] g;
        logic [Gf_width-1:0]      root;
        g    = '0;
        g[0] = Gf_width'(1);
        root = Gf_width'(1);
        for (int i = 0; i < int'(P); i++) begin
            for (int j = int'(P); j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul(g[j], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, Alpha);
        end
        return g[P-1:0];
    endfunction

    localparam coef_t Gen = gen_poly();

    localparam logic [CntW-1:0] DataLast = CntW'(K - 1);
    localparam logic [CntW-1:0] ParLast  = CntW'(P - 1);

    typedef enum logic [0:0] {
        StData,
        StParity
    } state_e;

    state_e                        state_q, state_d;
    logic   [CntW-1:0]             cnt_q, cnt_d;
    logic   [P-1:0][Gf_width-1:0]  r_q, r_d;
    logic   [Gf_width-1:0]         fb;
    logic                          xfer;

    assign fb   = data_in ^ r_q[P-1];
    assign xfer = data_out_req & data_out_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StData;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        unique case (state_q)
            StData: begin
                if (xfer) begin
                    r_d[0] = gf_mul(fb, Gen[0]);
                    for (int i = 1; i < int'(P); i++) begin
                        r_d[i] = r_q[i-1] ^ gf_mul(fb, Gen[i]);
                    end
                    if (cnt_q == DataLast) begin
                        state_d = StParity;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StParity: begin
                if (xfer) begin
                    // Shifting in zeros leaves r all-zero after the last parity symbol.
                    r_d = {r_q[P-2:0], {Gf_width{1'b0}}};
                    if (cnt_q == ParLast) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StData;
                cnt_d   = '0;
                r_d     = '0;
            end
        endcase
    end

    always_comb begin
        data_out     = data_in;
        data_out_req = data_in_req;
        data_in_ack  = data_out_ack;
        data_out_par = 1'b0;
        data_out_sop = 1'b0;
        unique case (state_q)
            StData: begin
                data_out_sop = (cnt_q == '0) && data_in_req;
            end
            StParity: begin
                data_out     = r_q[P-1];
                data_out_req = 1'b1;
                data_in_ack  = 1'b0;
                data_out_par = 1'b1;
            end
            default: begin
                data_out_req = 1'b0;
                data_in_ack  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_zl_rs_encoder.sv
// Randomized bench for zl_rs_encoder against a polynomial-long-division RS(204,188) model
// built on log/antilog tables, plus syndrome, backpressure, reset and linearity checks.
module tb_zl_rs_encoder;

    localparam int N = 204;
    localparam int K = 188;
    localparam int P = N - K;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic [7:0] data_in = 8'h00;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic [7:0] data_out;
    logic       data_out_sop;
    logic       data_out_par;

    always #5 clk = ~clk;

    zl_rs_encoder #(
        .N        (N),
        .K        (K),
        .Gf_width (8),
        .Gf_poly  (285)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_in      (data_in),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .data_out     (data_out),
        .data_out_sop (data_out_sop),
        .data_out_par (data_out_par)
    );

    int n_total = 0;
    int n_bad   = 0;

    int         exp_t [512];
    int         log_t [256];
    logic [7:0] gfull [P+1];

    logic [7:0] msg_q [$];
    logic [9:0] exp_q [$];
    logic [9:0] out_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(exp_t[log_t[a] + log_t[b]]);
    endfunction

    task automatic build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11D;
        end
        for (int i = 255; i < 512; i++) exp_t[i] = exp_t[i-255];
        log_t[0] = 0;
        for (int d = 0; d <= P; d++) gfull[d] = 8'h00;
        gfull[0] = 8'h01;
        for (int i = 0; i < P; i++) begin
            for (int d = P; d > 0; d--) gfull[d] = gfull[d-1] ^ gmul(gfull[d], 8'(exp_t[i]));
            gfull[0] = gmul(gfull[0], 8'(exp_t[i]));
        end
    endtask

    // Codeword = m(x)*x^P + (m(x)*x^P mod g(x)), index 0 = highest degree.
    task automatic encode(input logic [7:0] m [K], output logic [7:0] cw [N]);
        logic [7:0] w [N];
        logic [7:0] coef;
        for (int k = 0; k < N; k++) w[k] = (k < K) ? m[k] : 8'h00;
        for (int i = 0; i < K; i++) begin
            coef = w[i];
            for (int d = 0; d <= P; d++) w[i+P-d] = w[i+P-d] ^ gmul(coef, gfull[d]);
        end
        for (int k = 0; k < N; k++) cw[k] = (k < K) ? m[k] : w[k];
    endtask

    task automatic add_packet(input logic [7:0] m [K]);
        logic [7:0] cw [N];
        encode(m, cw);
        for (int k = 0; k < K; k++) msg_q.push_back(m[k]);
        for (int k = 0; k < N; k++) exp_q.push_back({(k == 0), (k >= K), cw[k]});
    endtask

    task automatic rand_msg(output logic [7:0] m [K]);
        for (int k = 0; k < K; k++) m[k] = 8'($urandom_range(255, 0));
    endtask

    task automatic get_cw(input int p, output logic [7:0] cw [N]);
        for (int k = 0; k < N; k++) begin
            cw[k] = (p*N + k < out_q.size()) ? out_q[p*N + k][7:0] : 8'h00;
        end
    endtask

    task automatic check_syndromes(input logic [7:0] cw [N]);
        logic [7:0] s;
        for (int i = 0; i < P; i++) begin
            s = 8'h00;
            for (int k = 0; k < N; k++) s = gmul(s, 8'(exp_t[i])) ^ cw[k];
            check_eq("syndrome", 32'(s), 32'h0);
        end
    endtask

    task automatic clear_queues();
        msg_q.delete();
        exp_q.delete();
        out_q.delete();
    endtask

    // Runs until max_out output transfers are seen; inputs driven on negedge, sampled 1ns later.
    task automatic drive_stream(input bit stall, input int max_out, output int n_cycles);
        int         got;
        int         budget;
        logic [7:0] held;
        bit         held_v;
        got      = 0;
        budget   = max_out * 4 + 200;
        held     = 8'h00;
        held_v   = 1'b0;
        n_cycles = 0;
        while (got < max_out && budget > 0) begin
            @(negedge clk);
            data_in_req  = (msg_q.size() > 0) && (!stall || $urandom_range(9, 0) >= 3);
            data_in      = (msg_q.size() > 0) ? msg_q[0] : 8'h00;
            data_out_ack = !stall || $urandom_range(9, 0) >= 3;
            #1;
            if (held_v) check_eq("par_stable", 32'(data_out), 32'(held));
            held_v = 1'b0;
            if (data_out_par) begin
                check_eq("in_ack_par", 32'(data_in_ack), 32'h0);
                if (!data_out_ack) begin
                    held   = data_out;
                    held_v = 1'b1;
                end
            end
            if (data_out_req && data_out_ack) begin
                out_q.push_back({data_out_sop, data_out_par, data_out});
                got++;
            end
            if (data_in_req && data_in_ack) void'(msg_q.pop_front());
            n_cycles++;
            budget--;
        end
        if (got < max_out) check_eq("stream_timeout", 32'(got), 32'(max_out));
        @(negedge clk);
        data_in_req  = 1'b0;
        data_out_ack = 1'b1;
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check_eq(tag, 32'(out_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] m  [K];
        logic [7:0] a  [K];
        logic [7:0] b  [K];
        logic [7:0] c  [K];
        logic [7:0] cw [N];
        logic [7:0] ca [N];
        logic [7:0] cb [N];
        logic [7:0] cc [N];
        int         cyc;

        build_tables();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_req", 32'(data_out_req), 32'h0);
        check_eq("rst_in_ack", 32'(data_in_ack), 32'h1);
        check_eq("rst_par", 32'(data_out_par), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        data_in_req = 1'b1;
        data_in     = 8'h5A;
        #1;
        check_eq("rst_pass_data", 32'(data_out), 32'h5A);
        check_eq("rst_pass_req", 32'(data_out_req), 32'h1);
        check_eq("rst_sop", 32'(data_out_sop), 32'h1);
        data_in_req = 1'b0;

        // All-zero message
        clear_queues();
        for (int k = 0; k < K; k++) m[k] = 8'h00;
        add_packet(m);
        drive_stream(1'b0, N, cyc);
        compare_stream("zero");

        // Impulse: parity must be the generator coefficients, highest degree first
        clear_queues();
        m[K-1] = 8'h01;
        add_packet(m);
        drive_stream(1'b0, N, cyc);
        compare_stream("impulse");
        for (int j = 0; j < P; j++) begin
            check_eq("impulse_g", 32'(out_q[K+j][7:0]), 32'(gfull[P-1-j]));
        end

        // Random back-to-back packets
        clear_queues();
        for (int p = 0; p < 50; p++) begin
            rand_msg(m);
            add_packet(m);
        end
        drive_stream(1'b0, 50*N, cyc);
        check_eq("no_gap_cycles", 32'(cyc), 32'(50*N));
        compare_stream("random");
        for (int p = 0; p < 50; p++) begin
            get_cw(p, cw);
            check_syndromes(cw);
        end

        // Backpressure on both sides
        clear_queues();
        for (int p = 0; p < 10; p++) begin
            rand_msg(m);
            add_packet(m);
        end
        drive_stream(1'b1, 10*N, cyc);
        compare_stream("backpressure");

        // Reset after 100 data symbols, then a fresh packet
        clear_queues();
        rand_msg(m);
        add_packet(m);
        drive_stream(1'b0, 100, cyc);
        reset_pulse();
        clear_queues();
        rand_msg(m);
        add_packet(m);
        drive_stream(1'b0, N, cyc);
        compare_stream("reset_data");

        // Reset after 5 parity symbols, then a fresh packet
        clear_queues();
        rand_msg(m);
        add_packet(m);
        drive_stream(1'b0, K + 5, cyc);
        reset_pulse();
        clear_queues();
        rand_msg(m);
        add_packet(m);
        drive_stream(1'b0, N, cyc);
        compare_stream("reset_par");

        // Linearity over 20 pairs
        clear_queues();
        for (int p = 0; p < 20; p++) begin
            rand_msg(a);
            rand_msg(b);
            for (int k = 0; k < K; k++) c[k] = a[k] ^ b[k];
            add_packet(a);
            add_packet(b);
            add_packet(c);
        end
        drive_stream(1'b0, 60*N, cyc);
        compare_stream("lin_stream");
        for (int p = 0; p < 20; p++) begin
            get_cw(3*p, ca);
            get_cw(3*p + 1, cb);
            get_cw(3*p + 2, cc);
            for (int j = K; j < N; j++) begin
                check_eq("linearity", 32'(cc[j]), 32'(ca[j] ^ cb[j]));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
